otter_iobus_periph: RTL

Memory-mapped peripheral responder for the OTTER MCU IOBUS. It decodes the MCU's IOBUS write and read traffic (IOBUS_ADDR/IOBUS_OUT/IOBUS_WR → IOBUS_IN), holds the LED and seven-segment output registers, and synchronises the board switches. It also provides a programmable down-counting timer whose event drives the MCU INTR input.

---
 rtl/otter_iobus_periph.sv | 117 +++++++++++
 1 files changed

// File: rtl/otter_iobus_periph.sv
// OTTER MCU IOBUS peripheral responder: LED/seven-segment registers, synchronised
// switches and a programmable down-counting timer that drives the MCU interrupt.
module otter_iobus_periph #(
   parameter logic [31:0] BASE_ADDR = 32'h1100_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] IOBUS_IN,
   output logic        INTR,
   input  logic [15:0] SWITCHES,
   output logic [15:0] LEDS,
   output logic [15:0] SSEG
);

   localparam logic [11:0] OFF_SW    = 12'h000;
   localparam logic [11:0] OFF_LEDS  = 12'h020;
   localparam logic [11:0] OFF_SSEG  = 12'h040;
   localparam logic [11:0] OFF_CTRL  = 12'h200;
   localparam logic [11:0] OFF_LOAD  = 12'h204;
   localparam logic [11:0] OFF_COUNT = 12'h208;
   localparam logic [11:0] OFF_IRQ   = 12'h20C;

   logic [15:0] sw_meta;
   logic [15:0] sw_sync;
   logic [2:0]  ctrl;
   logic [31:0] load;
   logic [31:0] count;
   logic [31:0] count_next;
   logic        pend;
   logic        tmr_event;
   logic        hit;
   logic [11:0] off;
   logic [31:0] rd_mux;
   logic        wr_leds;
   logic        wr_sseg;
   logic        wr_ctrl;
   logic        wr_load;
   logic        wr_irq;
   logic        addr_lsb_unused;

   // Word access only: the byte-lane bits never take part in decode.
   assign addr_lsb_unused = ^IOBUS_ADDR[1:0];
   assign hit = (IOBUS_ADDR[31:12] == BASE_ADDR[31:12]);
   assign off = {IOBUS_ADDR[11:2], 2'b00};

   assign wr_leds = IOBUS_WR & hit & (off == OFF_LEDS);
   assign wr_sseg = IOBUS_WR & hit & (off == OFF_SSEG);
   assign wr_ctrl = IOBUS_WR & hit & (off == OFF_CTRL);
   assign wr_load = IOBUS_WR & hit & (off == OFF_LOAD);
   assign wr_irq  = IOBUS_WR & hit & (off == OFF_IRQ);

   // Old EN is used, so a CTRL write landing on an event cycle still lets it fire.
   always_comb begin
      tmr_event  = ctrl[0] & (count == 32'd1);
      count_next = count;
      if (wr_load) begin
         count_next = IOBUS_OUT;
      end else if (ctrl[0]) begin
         if (count > 32'd1) begin
            count_next = count - 32'd1;
         end else if (count == 32'd1) begin
            count_next = ctrl[1] ? load : 32'd0;
         end
      end
   end

   always_comb begin
      rd_mux = 32'd0;
      if (hit) begin
         case (off)
            OFF_SW:    rd_mux = {16'd0, sw_sync};
            OFF_LEDS:  rd_mux = {16'd0, LEDS};
            OFF_SSEG:  rd_mux = {16'd0, SSEG};
            OFF_CTRL:  rd_mux = {29'd0, ctrl};
            OFF_LOAD:  rd_mux = load;
            OFF_COUNT: rd_mux = count;
            OFF_IRQ:   rd_mux = {31'd0, pend};
            default:   rd_mux = 32'd0;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sw_meta  <= 16'd0;
         sw_sync  <= 16'd0;
         LEDS     <= 16'd0;
         SSEG     <= 16'd0;
         ctrl     <= 3'd0;
         load     <= 32'd0;
         count    <= 32'd0;
         pend     <= 1'b0;
         IOBUS_IN <= 32'd0;
      end else begin
         sw_meta  <= SWITCHES;
         sw_sync  <= sw_meta;
         IOBUS_IN <= rd_mux;
         count    <= count_next;
         if (wr_leds) LEDS <= IOBUS_OUT[15:0];
         if (wr_sseg) SSEG <= IOBUS_OUT[15:0];
         if (wr_ctrl) ctrl <= IOBUS_OUT[2:0];
         if (wr_load) load <= IOBUS_OUT;
         // A timer event outranks a simultaneous software clear.
         if (tmr_event) begin
            pend <= 1'b1;
         end else if (wr_irq && IOBUS_OUT[0]) begin
            pend <= 1'b0;
         end
      end
   end

   assign INTR = pend & ctrl[2];

endmodule
